sram_arbiter: RTL and testbench

- Sole owner of the external 16-bit async SRAM port; shares it between the VGA scan-out read path and the pixel-buffer write path.
- Read path has absolute priority, so VGA fetches have fixed latency and never stall.
- Write path accepts one 24-bit pixel (rayID + RGB) per handshake and commits it as two SRAM halfword writes in cycles left idle by the read path.
- Sits between frame_buffer_handler's pixel FIFO / VGA fetch logic and the SRAM pins.

---
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: sole owner of the external 16-bit async SRAM port. Shares it
// between the VGA scan-out read path (absolute priority, fixed 2-cycle
// latency, fully pipelined) and the pixel write path. The write path accepts
// one 24-bit pixel per handshake and commits it as two halfword writes in
// cycles the read path leaves idle.
//
// Optional feature: define SRAM_ARB_STATS_EN to build saturating statistics
// counters (stat_rd, stat_wr, stat_stall). Without it the ports are tied to 0.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rd_req, rd_addr      VGA read request (one SRAM read per asserted cycle)
//   rd_valid, rd_data    read return, 2 cycles after rd_req
//   pix_valid/pix_ready  pixel handshake; pix_id = rayID, pix_color = {R,G,B}
//   wr_done              pulse when a pixel's second halfword is issued
//   sram_re/we/addr/io   SRAM pins; sram_io driven only while sram_we=1
//   sram_ub, sram_lb     SRAM byte enables
//   stat_rd/wr/stall     statistics counters
module sram_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 19,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [ID_W-1:0]   pix_id,
  input  logic [23:0]       pix_color,
  output logic              wr_done,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_io,
  output logic              sram_ub,
  output logic              sram_lb,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int unsigned COLOR_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_HI = 2'd1,
    WR_LO = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q;
  logic [COLOR_W-1:0]   color_q;
  logic [DATA_W-1:0]    wdata_q;

  logic                 accept_c;
  logic                 wr_issue_c;
  logic                 re_d, we_d, ub_d, lb_d, done_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;

  // Data bus is driven only during a write pin cycle.
  assign sram_io = sram_we ? wdata_q : {DATA_W{1'bz}};

  // Next state and next pin values; reads always win the cycle.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    wr_issue_c = 1'b0;
    re_d       = 1'b0;
    we_d       = 1'b0;
    ub_d       = 1'b0;
    lb_d       = 1'b0;
    done_d     = 1'b0;
    addr_d     = sram_addr;
    wdata_d    = wdata_q;

    if (rd_req) begin
      re_d   = 1'b1;
      ub_d   = 1'b1;
      lb_d   = 1'b1;
      addr_d = rd_addr;
    end

    case (state_q)
      IDLE: begin
        // pix_ready is low for the first cycle after reset, which gates this.
        if (pix_valid && pix_ready) begin
          accept_c = 1'b1;
          state_d  = WR_HI;
        end
      end
      WR_HI: begin
        if (!rd_req) begin
          wr_issue_c = 1'b1;
          we_d       = 1'b1;
          ub_d       = 1'b1;
          lb_d       = 1'b1;
          addr_d     = ADDR_W'({id_q, 1'b0});
          wdata_d    = DATA_W'(color_q[23:8]);
          state_d    = WR_LO;
        end
      end
      WR_LO: begin
        if (!rd_req) begin
          wr_issue_c = 1'b1;
          we_d       = 1'b1;
          lb_d       = 1'b1;
          done_d     = 1'b1;
          addr_d     = ADDR_W'({id_q, 1'b1});
          wdata_d    = DATA_W'({8'h00, color_q[7:0]});
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched pixel and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      color_q   <= '0;
      wdata_q   <= '0;
      pix_ready <= 1'b0;
      wr_done   <= 1'b0;
      sram_re   <= 1'b0;
      sram_we   <= 1'b0;
      sram_ub   <= 1'b0;
      sram_lb   <= 1'b0;
      sram_addr <= '0;
    end else begin
      state_q   <= state_d;
      pix_ready <= (state_d == IDLE);
      wr_done   <= done_d;
      sram_re   <= re_d;
      sram_we   <= we_d;
      sram_ub   <= ub_d;
      sram_lb   <= lb_d;
      sram_addr <= addr_d;
      wdata_q   <= wdata_d;
      if (accept_c) begin
        id_q    <= pix_id;
        color_q <= pix_color;
      end
    end
  end

  // Read return: the bus is sampled at the end of the read pin cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= sram_re;
      if (sram_re) begin
        rd_data <= sram_io;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      if (rd_req && (stat_rd != {STAT_W{1'b1}})) begin
        stat_rd <= stat_rd + STAT_W'(1);
      end
      if (wr_issue_c && (stat_wr != {STAT_W{1'b1}})) begin
        stat_wr <= stat_wr + STAT_W'(1);
      end
      if (rd_req && (state_q != IDLE) && (stat_stall != {STAT_W{1'b1}})) begin
        stat_stall <= stat_stall + STAT_W'(1);
      end
    end
  end
`else
  assign stat_rd    = '0;
  assign stat_wr    = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: random and directed stimulus, a transaction-level
// reference model producing expected pin activity and read data into queues,
// and a monitor that compares DUT outputs against them on the falling edge.
module tb_sram_arbiter;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 19;
  localparam int unsigned STAT_W = 32;
  localparam int unsigned MEM_N  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [ID_W-1:0]   pix_id = '0;
  logic [23:0]       pix_color = '0;
  logic              wr_done;
  logic              sram_re, sram_we, sram_ub, sram_lb;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_io;
  logic [STAT_W-1:0] stat_rd, stat_wr, stat_stall;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_id(pix_id), .pix_color(pix_color),
    .wr_done(wr_done),
    .sram_re(sram_re), .sram_we(sram_we), .sram_addr(sram_addr), .sram_io(sram_io),
    .sram_ub(sram_ub), .sram_lb(sram_lb),
    .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int unsigned a);
    return 16'((a * 40503) ^ 32'h0000_C3A5);
  endfunction

  // Behavioural async SRAM with byte enables.
  logic [15:0] mem [MEM_N];
  assign sram_io = (sram_re && !sram_we) ? mem[sram_addr[11:0]] : {DATA_W{1'bz}};

  initial begin : sram_model
    for (int i = 0; i < int'(MEM_N); i++) mem[i] = pat(i);
    forever begin
      @(posedge clk);
      if (sram_we) begin
        if (sram_ub) mem[sram_addr[11:0]][15:8] = sram_io[15:8];
        if (sram_lb) mem[sram_addr[11:0]][7:0]  = sram_io[7:0];
      end
    end
  end

  // Reference model: pending halfword count, expected pins and memory image.
  typedef struct { logic [19:0] addr; logic [15:0] data; logic ub; logic lb; } wr_t;
  typedef struct { logic [19:0] addr; logic [15:0] data; int due; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [15:0] refmem [MEM_N];
  int          cyc = 0;
  int          pend = 0;
  logic [18:0] m_id;
  logic [23:0] m_col;
  logic        exp_re = 0, exp_we = 0, exp_done = 0, exp_ready = 0;
  logic [19:0] exp_raddr = '0;
  logic [31:0] m_rd = 0, m_wr = 0, m_stall = 0;
  bit          chk_en = 0;

  initial begin : ref_model
    wr_t w;
    rd_t r;
    for (int i = 0; i < int'(MEM_N); i++) refmem[i] = pat(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend = 0; exp_ready = 0; exp_re = 0; exp_we = 0; exp_done = 0;
        rd_q.delete(); wr_q.delete();
        m_rd = 0; m_wr = 0; m_stall = 0;
      end else begin
        exp_re = rd_req; exp_we = 0; exp_done = 0;
        if (rd_req) begin
          exp_raddr = rd_addr;
          r.addr = rd_addr; r.data = refmem[rd_addr[11:0]]; r.due = cyc + 1;
          rd_q.push_back(r);
          if (m_rd != 32'hFFFF_FFFF) m_rd++;
          if (pend != 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
        end else if (pend != 0) begin
          if (pend == 2) begin
            w.addr = {m_id, 1'b0}; w.data = m_col[23:8]; w.ub = 1; w.lb = 1;
            refmem[w.addr[11:0]] = w.data;
          end else begin
            w.addr = {m_id, 1'b1}; w.data = {8'h00, m_col[7:0]}; w.ub = 0; w.lb = 1;
            refmem[w.addr[11:0]][7:0] = m_col[7:0];
          end
          wr_q.push_back(w);
          exp_we = 1;
          pend--;
          exp_done = (pend == 0);
          if (m_wr != 32'hFFFF_FFFF) m_wr++;
        end
        if (pix_valid && exp_ready) begin
          pend = 2; m_id = pix_id; m_col = pix_color;
        end
        exp_ready = (pend == 0);
      end
    end
  end

  // Monitor: compares pins and read returns against the model each cycle.
  initial begin : monitor
    wr_t w;
    rd_t r;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("sram_re", 32'(sram_re), 32'(exp_re));
        chk("sram_we", 32'(sram_we), 32'(exp_we));
        chk("wr_done", 32'(wr_done), 32'(exp_done));
        chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
        if (sram_re) begin
          chk("rd_pin_addr", 32'(sram_addr), 32'(exp_raddr));
          chk("rd_pin_bytes", 32'({sram_ub, sram_lb}), 32'h3);
        end
        if (sram_we) begin
          if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(sram_addr), 32'(w.addr));
            chk("wr_data", 32'(sram_io), 32'(w.data));
            chk("wr_bytes", 32'({sram_ub, sram_lb}), 32'({w.ub, w.lb}));
          end
        end
        if (!sram_re && !sram_we) chk("idle_bytes", 32'({sram_ub, sram_lb}), 32'd0);
        if (rd_valid) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
          else begin
            r = rd_q.pop_front();
            chk("rd_latency", 32'(cyc), 32'(r.due));
            chk("rd_data", 32'(rd_data), 32'(r.data));
          end
        end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
          chk("rd_missing", 32'd0, 32'd1);
          void'(rd_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit seen = 0;
    rd_req = 0; pix_valid = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (pix_ready) seen = 1;
    end
    if (!seen) chk("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pixel(input logic [18:0] id, input logic [23:0] col);
    pix_valid = 1; pix_id = id; pix_color = col;
    step();
    pix_valid = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_done) begin
        seen = 1;
        chk("ready_with_done", 32'(pix_ready), 32'd1);
      end
    end
    if (!seen) chk("wr_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_range(input int unsigned base, input int unsigned n);
    for (int unsigned a = 0; a < n; a++) begin
      rd_req = 1; rd_addr = 20'(base + a);
      step();
    end
    rd_req = 0;
    repeat (4) step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] stall0;
    int          n;
    bit          seen;
    stall0 = 0;

    // Reset, then idle.
    step(); chk_en = 1;
    step(); rst = 0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_pix_ready", 32'(pix_ready), 32'd1);
    chk("reset_re_we", 32'({sram_re, sram_we}), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);

    // Single pixel, no reads.
    send_pixel(19'd1, 24'h123456);
    wait_done();

    // Pipelined reads.
    step();
    read_range(32'h10, 3);

    // Priority: pixel pending while reads hold the port for 20 cycles.
    wait_ready();
    send_pixel(19'd0, 24'($urandom));
`ifdef SRAM_ARB_STATS_EN
    stall0 = stat_stall;
`endif
    rd_req = 1;
    repeat (20) begin
      rd_addr = 20'(32'h800 + ($urandom % 2048));
      step();
    end
    rd_req = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (wr_done) seen = 1;
    end
    // Word0 decided in the first idle cycle, word1 (with wr_done) on pins two cycles later.
    chk("wr_after_drop_cycles", 32'(n), 32'd3);
`ifdef SRAM_ARB_STATS_EN
    chk("stat_stall_20", stat_stall - stall0, 32'd20);
`endif

    // Interleave: alternating reads with pixels always offered.
    wait_ready();
    for (int i = 0; i < 40; i++) begin
      rd_req = i[0]; rd_addr = 20'(32'h800 + ($urandom % 2048));
      pix_valid = 1; pix_id = 19'($urandom % 64); pix_color = 24'($urandom);
      step();
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rd_req = ($urandom % 3) != 0; rd_addr = 20'(32'h800 + ($urandom % 2048));
      pix_valid = $urandom % 2; pix_id = 19'($urandom % 64); pix_color = 24'($urandom);
      step();
    end

    // Read back the pixel region.
    wait_ready();
    read_range(0, 128);

    // Reset while the second halfword is pending.
    wait_ready();
    send_pixel(19'd5, 24'hABCDEF);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_we", 32'(sram_we), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("rst_stats", stat_rd | stat_wr | stat_stall, 32'd0);
`endif
    wait_ready();
    send_pixel(19'd6, 24'h13579B);
    wait_done();
    step();
    read_range(10, 4);

    // Final bookkeeping.
    repeat (5) step();
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("stat_rd", stat_rd, m_rd);
    chk("stat_wr", stat_wr, m_wr);
    chk("stat_stall", stat_stall, m_stall);
`else
    chk("stat_tied_zero", stat_rd | stat_wr | stat_stall, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
